bus_source_arbiter: RTL and testbench

BUS_SOURCE_ARBITER -- requirements
Module: bus_source_arbiter

---
 rtl/bus_source_arbiter_pkg.sv | 17 +
 rtl/bus_source_arbiter_if.sv | 33 +++
 rtl/bus_source_arbiter_prio_pick.sv | 46 ++++
 rtl/bus_source_arbiter.sv | 124 ++++++++++++
 tb/tb_bus_source_arbiter.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_source_arbiter_pkg.sv
// Bus source arbiter shared types.
// State encoding and default sizing.
package bus_source_arbiter_pkg;

  localparam int NUM_SRC_DEF   = 32;
  localparam int ERR_CNT_W_DEF = 8;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    HELD
  } state_t;

endpackage

// File: rtl/bus_source_arbiter_if.sv
// Bus source arbiter handshake bundle.
// Control unit is master, arbiter is slave.
interface bus_source_arbiter_if
  import bus_source_arbiter_pkg::*;
#(
  parameter int NUM_SRC   = NUM_SRC_DEF,
  parameter int SEL_W     = $clog2(NUM_SRC),
  parameter int ERR_CNT_W = ERR_CNT_W_DEF
) ();

  logic [NUM_SRC-1:0]   src_req;
  logic                 mode;
  logic                 hold;
  logic                 err_clr;
  logic [SEL_W-1:0]     select_out;
  logic                 select_valid;
  logic                 conflict;
  logic                 err_sticky;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output src_req, mode, hold, err_clr,
    input  select_out, select_valid,
    input  conflict, err_sticky, err_count
  );

  modport slave (
    input  src_req, mode, hold, err_clr,
    output select_out, select_valid,
    output conflict, err_sticky, err_count
  );

endinterface

// File: rtl/bus_source_arbiter_prio_pick.sv
// Winner search: highest set bit (fixed)
// or first set bit at/after start (round-robin).
module prio_pick
  import bus_source_arbiter_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int SEL_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SEL_W-1:0]   start,
  input  logic               mode,
  output logic [SEL_W-1:0]   idx,
  output logic               found
);

  logic [2*NUM_SRC-1:0] rot;
  logic [SEL_W:0]       sum;

  assign rot = {req, req} >> start;

  // scan; the last hit in loop order wins
  always_comb begin
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    if (mode == MODE_FIXED) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (req[i]) begin
          idx   = SEL_W'(i);
          found = 1'b1;
        end
      end
    end else begin
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
        if (rot[i]) begin
          sum = {1'b0, start} + (SEL_W+1)'(i);
          if (sum >= (SEL_W+1)'(NUM_SRC))
            sum = sum - (SEL_W+1)'(NUM_SRC);
          idx   = sum[SEL_W-1:0];
          found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bus_source_arbiter.sv
// Bus source arbiter: fixed/round-robin grant
// with hold, plus multi-driver conflict status.
module bus_source_arbiter
  import bus_source_arbiter_pkg::*;
#(
  parameter int NUM_SRC   = NUM_SRC_DEF,
  parameter int SEL_W     = $clog2(NUM_SRC),
  parameter int ERR_CNT_W = ERR_CNT_W_DEF
) (
  input logic                 clock,
  input logic                 clear_n,
  bus_source_arbiter_if.slave bus
);

  state_t               state, state_nx;
  logic [SEL_W-1:0]     sel_q, sel_nx;
  logic [SEL_W-1:0]     last_grant, lg_nx;
  logic [SEL_W-1:0]     start, pick_idx;
  logic                 valid_q, valid_nx;
  logic                 pick_found;
  logic                 any_req, own_req, multi;
  logic                 arb, go_idle;
  logic                 conf_q, sticky_q;
  logic [ERR_CNT_W-1:0] cnt_q;

  assign any_req = |bus.src_req;
  assign own_req = bus.src_req[sel_q];
  assign multi   = (bus.src_req &
                   (bus.src_req - NUM_SRC'(1))) != '0;

  assign start = (last_grant == SEL_W'(NUM_SRC - 1))
               ? '0 : last_grant + SEL_W'(1);

  prio_pick #(
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SEL_W)
  ) u_pick (
    .req   (bus.src_req),
    .start (start),
    .mode  (bus.mode),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // next state, grant and last-grant selection
  always_comb begin
    state_nx = state;
    sel_nx   = sel_q;
    valid_nx = valid_q;
    lg_nx    = last_grant;
    arb      = 1'b0;
    go_idle  = 1'b0;
    unique case (state)
      IDLE: arb = any_req;
      GRANT: begin
        if (!any_req)
          go_idle = 1'b1;
        else if (bus.hold && own_req)
          state_nx = HELD;
        else
          arb = 1'b1;
      end
      HELD: begin
        if (!own_req)
          go_idle = 1'b1;
        else if (!bus.hold)
          arb = 1'b1;
      end
      default: go_idle = 1'b1;
    endcase
    if (go_idle) begin
      state_nx = IDLE;
      sel_nx   = '0;
      valid_nx = 1'b0;
    end
    if (arb && pick_found) begin
      state_nx = GRANT;
      sel_nx   = pick_idx;
      valid_nx = 1'b1;
      lg_nx    = pick_idx;
    end
  end

  // grant state registers
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state      <= IDLE;
      sel_q      <= '0;
      valid_q    <= 1'b0;
      last_grant <= SEL_W'(NUM_SRC - 1);
    end else begin
      state      <= state_nx;
      sel_q      <= sel_nx;
      valid_q    <= valid_nx;
      last_grant <= lg_nx;
    end
  end

  // conflict pulse and error status; clear wins
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      conf_q   <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      conf_q <= multi;
      if (bus.err_clr) begin
        sticky_q <= 1'b0;
        cnt_q    <= '0;
      end else if (multi) begin
        sticky_q <= 1'b1;
        if (cnt_q != '1)
          cnt_q <= cnt_q + ERR_CNT_W'(1);
      end
    end
  end

  assign bus.select_out   = sel_q;
  assign bus.select_valid = valid_q;
  assign bus.conflict     = conf_q;
  assign bus.err_sticky   = sticky_q;
  assign bus.err_count    = cnt_q;

endmodule

// File: tb/tb_bus_source_arbiter.sv
// Bus source arbiter bench: directed cases
// plus random traffic against a reference model.
module tb_bus_source_arbiter;
  import bus_source_arbiter_pkg::*;

  localparam int N  = 32;
  localparam int SW = 5;
  localparam int CW = 8;

  logic clock   = 1'b0;
  logic clear_n = 1'b0;

  always #5 clock = ~clock;

  bus_source_arbiter_if #(
    .NUM_SRC(N), .SEL_W(SW), .ERR_CNT_W(CW)
  ) bus ();

  bus_source_arbiter #(
    .NUM_SRC(N), .SEL_W(SW), .ERR_CNT_W(CW)
  ) dut (
    .clock   (clock),
    .clear_n (clear_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  int m_sel, m_lg, m_cnt;
  bit m_valid, m_held, m_conf, m_sticky;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d",
               tag, got, exp);
    end
  endtask

  function automatic int winner(
    input logic [N-1:0] r, input bit md, input int lg);
    if (!md) begin
      for (int i = N - 1; i >= 0; i--)
        if (r[i]) return i;
    end else begin
      for (int off = 1; off <= N; off++)
        if (r[(lg + off) % N]) return (lg + off) % N;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_sel = 0; m_valid = 0; m_held = 0;
    m_lg = N - 1; m_conf = 0;
    m_sticky = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    logic [N-1:0] r;
    bit arb, idle;
    r = bus.src_req;
    arb = 0; idle = 0;
    m_conf = ($countones(r) > 1);
    if (bus.err_clr) begin
      m_sticky = 0; m_cnt = 0;
    end else if (m_conf) begin
      m_sticky = 1;
      if (m_cnt < 255) m_cnt++;
    end
    if (!m_valid) arb = (r != 0);
    else if (m_held) begin
      if (!r[m_sel]) idle = 1;
      else if (!bus.hold) arb = 1;
    end else begin
      if (r == 0) idle = 1;
      else if (bus.hold && r[m_sel]) m_held = 1;
      else arb = 1;
    end
    if (idle) begin
      m_valid = 0; m_sel = 0; m_held = 0;
    end
    if (arb) begin
      m_sel = winner(r, bus.mode, m_lg);
      m_lg = m_sel; m_valid = 1; m_held = 0;
    end
  endtask

  task automatic compare();
    check("sel", 64'(bus.select_out), 64'(m_sel));
    check("valid", 64'(bus.select_valid), 64'(m_valid));
    check("conflict", 64'(bus.conflict), 64'(m_conf));
    check("sticky", 64'(bus.err_sticky), 64'(m_sticky));
    check("count", 64'(bus.err_count), 64'(m_cnt));
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    compare();
  endtask

  task automatic drive(input logic [N-1:0] r,
                       input bit h, input bit md,
                       input bit clr);
    bus.src_req = r;
    bus.hold    = h;
    bus.mode    = md;
    bus.err_clr = clr;
  endtask

  task automatic do_reset();
    clear_n = 1'b0;
    model_reset();
    #2;
    compare();
    check("rst_state", 64'(dut.state), 64'(IDLE));
    check("rst_lg", 64'(dut.last_grant), 64'(N - 1));
    @(negedge clock);
    clear_n = 1'b1;
  endtask

  function automatic logic [N-1:0] bits(input int a,
                                        input int b,
                                        input int c);
    logic [N-1:0] v;
    v = '0;
    if (a >= 0) v[a] = 1'b1;
    if (b >= 0) v[b] = 1'b1;
    if (c >= 0) v[c] = 1'b1;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] r;
    int seq[4];
    bit md;
    seq = '{2, 9, 2, 9};
    drive('0, 0, 0, 0);
    model_reset();
    #12;
    do_reset();

    drive(bits(21, -1, -1), 0, 0, 0);
    tick();
    check("r38_sel", 64'(bus.select_out), 21);
    check("r38_valid", 64'(bus.select_valid), 1);
    check("r38_conf", 64'(bus.conflict), 0);

    drive(bits(3, 15, 31), 0, 0, 0);
    tick();
    check("r39_sel", 64'(bus.select_out), 31);
    check("r39_conf", 64'(bus.conflict), 1);
    check("r39_sticky", 64'(bus.err_sticky), 1);
    check("r39_cnt", 64'(bus.err_count), 1);
    drive(bits(31, -1, -1), 0, 0, 0);
    tick();
    check("r39_once", 64'(bus.conflict), 0);

    do_reset();
    drive(bits(2, 9, -1), 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("r40_rr", 64'(bus.select_out), 64'(seq[i]));
    end

    drive(bits(5, -1, -1), 0, 0, 0);
    tick();
    check("r41_sel", 64'(bus.select_out), 5);
    drive(bits(5, 7, -1), 1, 0, 0);
    tick();
    tick();
    check("r41_frozen", 64'(bus.select_out), 5);
    check("r41_held", 64'(dut.state), 64'(HELD));
    drive(bits(7, -1, -1), 1, 0, 0);
    tick();
    check("r41_drop", 64'(bus.select_valid), 0);
    check("r41_idle", 64'(dut.state), 64'(IDLE));

    drive('0, 0, 0, 1);
    tick();
    drive(bits(0, 1, -1), 0, 0, 0);
    for (int i = 0; i < 258; i++) tick();
    check("r42_sat", 64'(bus.err_count), 255);
    drive(bits(0, 1, -1), 0, 0, 1);
    tick();
    check("r42_clr_cnt", 64'(bus.err_count), 0);
    check("r42_clr_conf", 64'(bus.conflict), 1);

    drive(bits(5, -1, -1), 0, 0, 0);
    tick();
    drive(bits(5, 7, -1), 1, 0, 0);
    tick();
    tick();
    check("r43_pre_held", 64'(dut.state), 64'(HELD));
    check("r43_pre_cnt", 64'(bus.err_count), 2);
    #3;
    clear_n = 1'b0;
    model_reset();
    #1;
    check("r43_valid", 64'(bus.select_valid), 0);
    check("r43_cnt", 64'(bus.err_count), 0);
    @(negedge clock);
    clear_n = 1'b1;

    md = 0;
    for (int it = 0; it < 3000; it++) begin
      int k;
      if ($urandom_range(0, 99) == 0) begin
        clear_n = 1'b0;
        model_reset();
        #1;
        compare();
        @(negedge clock);
        clear_n = 1'b1;
      end
      k = $urandom_range(0, 9);
      r = '0;
      if (k < 2) r = '0;
      else if (k < 6) r[$urandom_range(0, N - 1)] = 1'b1;
      else if (k < 8) begin
        if (m_valid) r[m_sel] = 1'b1;
        if ($urandom_range(0, 1) == 1)
          r[$urandom_range(0, N - 1)] = 1'b1;
      end else r = N'($urandom & $urandom);
      if ($urandom_range(0, 19) == 0) md = ~md;
      drive(r, ($urandom_range(0, 9) < 4), md,
            ($urandom_range(0, 29) == 0));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
